// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register, one-entry hold
// buffer for decode stalls, and a two-bubble redirect for jumps/branches.
// Instruction memory is synchronous: InstrData returns the word addressed
// by InstrAddr on the previous cycle, so the word currently on InstrData
// always belongs to address PC - PC_STEP.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter logic [31:0] PC_STEP    = 32'd1,
   parameter logic [4:0]  NOP_OPCODE = 5'b10111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  MuxDireccionPC,
   input  logic [31:0] JumpAddr,
   input  logic [31:0] BranchAddr,
   output logic [31:0] InstrAddr,
   input  logic [31:0] InstrData,
   output logic [31:0] Instruction,
   output logic [4:0]  Opcode,
   output logic [4:0]  OpCodeIDEXOUT,
   output logic [31:0] PCOut,
   output logic        Valid
);

   localparam logic [31:0] NOP_WORD = {NOP_OPCODE, 27'b0};

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t      state, state_nx;

   logic [31:0] pc, pc_nx;
   logic [31:0] instr, instr_nx;
   logic [31:0] pc_out, pc_out_nx;
   logic        valid, valid_nx;
   logic [4:0]  idex_op, idex_op_nx;
   logic [31:0] hold_data, hold_data_nx;
   logic        hold_valid, hold_valid_nx;

   logic        take_jump;
   logic        take_branch;
   logic        redirect;

   // Modulo-2^32 PC arithmetic; overflow wraps silently.
   function automatic logic [31:0] pc_inc(input logic [31:0] p);
      return p + PC_STEP;
   endfunction

   function automatic logic [31:0] pc_dec(input logic [31:0] p);
      return p - PC_STEP;
   endfunction

   assign take_jump   = (MuxDireccionPC == 2'b01);
   assign take_branch = (MuxDireccionPC == 2'b10);
   assign redirect    = take_jump | take_branch;

   // Registered outputs; Opcode is the only combinational output.
   assign InstrAddr     = pc;
   assign Instruction   = instr;
   assign Opcode        = instr[31:27];
   assign OpCodeIDEXOUT = idex_op;
   assign PCOut         = pc_out;
   assign Valid         = valid;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FILL;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and next-value logic for PC, IF/ID, ID/EX opcode and hold buffer.
   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      instr_nx      = instr;
      pc_out_nx     = pc_out;
      valid_nx      = valid;
      hold_data_nx  = hold_data;
      hold_valid_nx = hold_valid;
      idex_op_nx    = Opcode;

      // A taken branch squashes the instruction in decode; a stall in RUN
      // inserts a bubble into execute. A jump still advances into execute.
      if (take_branch) begin
         idex_op_nx = NOP_OPCODE;
      end else if (!take_jump && (state == S_RUN) && stall) begin
         idex_op_nx = NOP_OPCODE;
      end

      if (redirect) begin
         // Redirect wins over everything: the in-flight memory word is
         // wrong-path, so IF/ID takes a bubble and FLUSH drops the next one.
         pc_nx         = take_jump ? JumpAddr : BranchAddr;
         instr_nx      = NOP_WORD;
         valid_nx      = 1'b0;
         hold_valid_nx = 1'b0;
         state_nx      = S_FLUSH;
      end else begin
         unique case (state)
            S_FILL, S_FLUSH: begin
               // No usable word on InstrData yet; stall is ignored here.
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
               pc_nx    = pc_inc(pc);
               state_nx = S_RUN;
            end
            S_RUN: begin
               if (stall) begin
                  // PC holds, so the memory will re-read PC next cycle and
                  // the word for PC - PC_STEP would be lost; park it once.
                  if (!hold_valid) begin
                     hold_data_nx  = InstrData;
                     hold_valid_nx = 1'b1;
                  end
               end else begin
                  instr_nx      = hold_valid ? hold_data : InstrData;
                  pc_out_nx     = pc_dec(pc);
                  valid_nx      = 1'b1;
                  hold_valid_nx = 1'b0;
                  pc_nx         = pc_inc(pc);
               end
            end
            default: begin
               instr_nx = NOP_WORD;
               valid_nx = 1'b0;
               state_nx = S_FILL;
            end
         endcase
      end
   end

   // PC, IF/ID, ID/EX opcode and hold-valid registers with reset values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         instr      <= NOP_WORD;
         pc_out     <= RESET_PC;
         valid      <= 1'b0;
         idex_op    <= NOP_OPCODE;
         hold_valid <= 1'b0;
      end else begin
         pc         <= pc_nx;
         instr      <= instr_nx;
         pc_out     <= pc_out_nx;
         valid      <= valid_nx;
         idex_op    <= idex_op_nx;
         hold_valid <= hold_valid_nx;
      end
   end

   // Hold buffer data; only meaningful while hold_valid is set.
   always_ff @(posedge clk) begin
      hold_data <= hold_data_nx;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Two instances share the
// control inputs: dut (RESET_PC=0) and dut_w (RESET_PC=FFFFFFFF) for wrap.
// Memory word at address a is {a[4:0], a[26:0]}, so opcode = a[4:0].
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  mux;
   logic [31:0] jump_addr;
   logic [31:0] branch_addr;

   logic [31:0] instr_addr,  instr_addr_w;
   logic [31:0] instr_data,  instr_data_w;
   logic [31:0] instruction, instruction_w;
   logic [4:0]  opcode,      opcode_w;
   logic [4:0]  idex,        idex_w;
   logic [31:0] pc_out,      pc_out_w;
   logic        valid,       valid_w;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [4:0] NOP = 5'b10111;

   // mask bits: 0 Valid, 1 PCOut, 2 Opcode, 3 OpCodeIDEXOUT, 4 InstrAddr
   typedef struct {
      bit          sel;
      logic [4:0]  m;
      logic        v;
      logic [31:0] pc;
      logic [4:0]  op;
      logic [4:0]  idex;
      logic [31:0] ia;
      string       tag;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[4:0], a[26:0]};
   endfunction

   always @(posedge clk) begin
      instr_data   <= mem_word(instr_addr);
      instr_data_w <= mem_word(instr_addr_w);
   end

   fetch_unit #(.RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .stall(stall), .MuxDireccionPC(mux),
      .JumpAddr(jump_addr), .BranchAddr(branch_addr),
      .InstrAddr(instr_addr), .InstrData(instr_data),
      .Instruction(instruction), .Opcode(opcode), .OpCodeIDEXOUT(idex),
      .PCOut(pc_out), .Valid(valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFFFFFF)) dut_w (
      .clk(clk), .reset(reset), .stall(stall), .MuxDireccionPC(mux),
      .JumpAddr(jump_addr), .BranchAddr(branch_addr),
      .InstrAddr(instr_addr_w), .InstrData(instr_data_w),
      .Instruction(instruction_w), .Opcode(opcode_w), .OpCodeIDEXOUT(idex_w),
      .PCOut(pc_out_w), .Valid(valid_w)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, want);
   endtask

   // Monitor: at each falling edge, compare everything expected for the last rising edge.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.m[0]) chk({e.tag, ".Valid"},         e.sel ? 32'(valid_w)  : 32'(valid),  32'(e.v));
         if (e.m[1]) chk({e.tag, ".PCOut"},         e.sel ? pc_out_w      : pc_out,      e.pc);
         if (e.m[2]) chk({e.tag, ".Opcode"},        e.sel ? 32'(opcode_w) : 32'(opcode), 32'(e.op));
         if (e.m[3]) chk({e.tag, ".OpCodeIDEXOUT"}, e.sel ? 32'(idex_w)   : 32'(idex),   32'(e.idex));
         if (e.m[4]) chk({e.tag, ".InstrAddr"},     e.sel ? instr_addr_w  : instr_addr,  e.ia);
      end
   end

   task automatic expect_out(input bit sel, input logic [4:0] m, input logic v,
                             input logic [31:0] pc, input logic [4:0] op,
                             input logic [4:0] id, input logic [31:0] ia,
                             input string tag);
      exp_t e;
      e.sel = sel; e.m = m; e.v = v; e.pc = pc; e.op = op;
      e.idex = id; e.ia = ia; e.tag = tag;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs, then return right after the rising edge.
   task automatic cyc(input logic r, input logic s, input logic [1:0] m,
                      input logic [31:0] ja, input logic [31:0] ba);
      #1;
      reset = r; stall = s; mux = m; jump_addr = ja; branch_addr = ba;
      @(posedge clk);
   endtask

   // Expect a valid instruction fetched from address a in IF/ID.
   task automatic expect_run(input logic [31:0] a, input string tag);
      expect_out(0, 5'b00111, 1'b1, a, a[4:0], 5'd0, 32'd0, tag);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; mux = 2'b00; jump_addr = '0; branch_addr = '0;

      // Reset state
      cyc(1, 0, 2'b00, 0, 0);
      cyc(1, 0, 2'b00, 0, 0);
      expect_out(0, 5'b11111, 1'b0, 32'h0, NOP, NOP, 32'h0, "rst");
      expect_out(1, 5'b10011, 1'b0, 32'hFFFFFFFF, NOP, NOP, 32'hFFFFFFFF, "rst_w");

      // Fill and sequential fetch
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b10001, 1'b0, 0, 0, 0, 32'h1, "fill");
      expect_out(1, 5'b00001, 1'b0, 0, 0, 0, 0, "fill_w");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h0, 5'd0, NOP, 0, "seq0");
      expect_out(1, 5'b00111, 1'b1, 32'hFFFFFFFF, 5'h1F, 0, 0, "wrap0");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h1, 5'd1, 5'd0, 0, "seq1");
      expect_out(1, 5'b00111, 1'b1, 32'h0, 5'd0, 0, 0, "wrap1");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h2, 5'd2, 5'd1, 0, "seq2");
      expect_out(1, 5'b00111, 1'b1, 32'h1, 5'd1, 0, 0, "wrap2");
      for (int i = 3; i <= 5; i++) begin
         cyc(0, 0, 2'b00, 0, 0);
         expect_run(i, "seq");
      end

      // Jump to 0x40 while IF/ID holds PC 5
      cyc(0, 0, 2'b01, 32'h40, 0);
      expect_out(0, 5'b11001, 1'b0, 0, 0, 5'd5, 32'h40, "jmp_e0");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01001, 1'b0, 0, 0, NOP, 0, "jmp_e1");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h40, 5'd0, NOP, 0, "jmp_tgt");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h41, 5'd1, 5'd0, 0, "jmp_tgt1");

      // Branch to 0x80
      cyc(0, 0, 2'b10, 0, 32'h80);
      expect_out(0, 5'b11001, 1'b0, 0, 0, NOP, 32'h80, "br_e0");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b00001, 1'b0, 0, 0, 0, 0, "br_e1");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h80, "br_tgt");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h81, "br_tgt1");

      // Jump to 5 so IF/ID reaches PC 7
      cyc(0, 0, 2'b01, 32'h5, 0);
      expect_out(0, 5'b01000, 1'b0, 0, 0, 5'd1, 0, "j5_e0");
      cyc(0, 0, 2'b00, 0, 0);
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(5, "j5_a");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(6, "j5_b");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(7, "j5_c");

      // Stall three cycles at PC 7
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 2'b00, 0, 0);
         expect_out(0, 5'b11011, 1'b1, 32'h7, 0, NOP, 32'h9, "stall");
      end
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h8, 5'd8, 5'd7, 0, "rel8");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b01111, 1'b1, 32'h9, 5'd9, 5'd8, 0, "rel9");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'hA, "rel10");

      // Stall, then stall together with jump to 0x20: hold buffer discarded
      cyc(0, 1, 2'b00, 0, 0);
      expect_out(0, 5'b01011, 1'b1, 32'hA, 0, NOP, 0, "sj_stall");
      cyc(0, 1, 2'b01, 32'h20, 0);
      expect_out(0, 5'b11001, 1'b0, 0, 0, 5'd10, 32'h20, "sj_redir");
      cyc(0, 1, 2'b00, 0, 0);
      expect_out(0, 5'b11001, 1'b0, 0, 0, NOP, 32'h21, "sj_flush");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h20, "sj_tgt");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h21, "sj_tgt1");

      // Reset in the middle of a stall discards the hold state
      cyc(0, 1, 2'b00, 0, 0);
      cyc(1, 1, 2'b00, 0, 0);
      expect_out(0, 5'b11011, 1'b0, 32'h0, 0, NOP, 32'h0, "rst_mid");
      cyc(0, 0, 2'b00, 0, 0);
      expect_out(0, 5'b00001, 1'b0, 0, 0, 0, 0, "rst_fill");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h0, "rst_seq0");
      cyc(0, 0, 2'b00, 0, 0);
      expect_run(32'h1, "rst_seq1");

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
